// File: rtl/zoom_scheduler.sv
// zoom_scheduler: sequences line-buffer reads for one frame and produces the
// zoomed pixel stream (1x pass-through, 2x replicate, 2x decimate).
// A 2-entry skid FIFO absorbs the 1-cycle buffer read latency. A read is only
// issued while FIFO occupancy plus reads still in flight stays below 2, so
// every read already launched always has a FIFO slot when it lands. The output
// register sits behind the FIFO and acts as the FIFO head for replication.
module zoom_scheduler #(
  parameter int IMG_W = 320,
  parameter int IMG_H = 240
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       start_in,
  input  logic [1:0] mode_in,
  input  logic       line_ready_in,
  output logic       line_rd_en_out,
  output logic       line_rewind_out,
  output logic       line_release_out,
  input  logic [7:0] pixel_in,
  output logic [7:0] pixel_out,
  output logic       pixel_valid_out,
  input  logic       pixel_ready_in,
  output logic       busy_out,
  output logic       frame_done_out
);

  localparam int COL_W  = $clog2(IMG_W + 1);
  localparam int ROW_W  = $clog2(IMG_H + 1);
  localparam int BEAT_W = $clog2(2 * IMG_W + 1);

  localparam logic [COL_W-1:0]  RD_TOTAL    = COL_W'(IMG_W);
  localparam logic [COL_W-1:0]  COL_ONE     = COL_W'(1);
  localparam logic [ROW_W-1:0]  ROW_LAST    = ROW_W'(IMG_H - 1);
  localparam logic [ROW_W-1:0]  ROW_ONE     = ROW_W'(1);
  localparam logic [BEAT_W-1:0] BEAT_ONE    = BEAT_W'(1);
  localparam logic [BEAT_W-1:0] BEATS_1X_M1 = BEAT_W'(IMG_W - 1);
  localparam logic [BEAT_W-1:0] BEATS_ZI_M1 = BEAT_W'(2 * IMG_W - 1);
  localparam logic [BEAT_W-1:0] BEATS_ZO_M1 = BEAT_W'(IMG_W / 2 - 1);

  localparam logic [1:0] MODE_1X = 2'b00;
  localparam logic [1:0] MODE_ZI = 2'b01;
  localparam logic [1:0] MODE_ZO = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_LINE = 3'd1,
    S_RUN       = 3'd2,
    S_LINE_END  = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t            r_state;
  logic [1:0]        r_mode;
  logic [ROW_W-1:0]  r_row;
  logic [COL_W-1:0]  r_rd_cnt;
  logic [BEAT_W-1:0] r_out_cnt;
  logic              r_pass;
  logic              r_beats_done;
  logic              r_rd_keep;   // keep flag travelling with line_rd_en_out
  logic              r_rd_d;      // pixel_in carries read data this cycle
  logic              r_keep_d;    // that data is to be kept (not decimated)
  logic              r_rep;       // zoom-in: current output already accepted once
  logic [7:0]        r_fifo_mem [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_fifo_cnt;

  logic              w_zin;
  logic              w_zout;
  logic              w_in_valid;
  logic              w_accept;
  logic              w_out_free;
  logic              w_load;
  logic              w_pop;
  logic              w_push;
  logic [7:0]        w_load_data;
  logic [1:0]        w_cnt_next;
  logic              w_issue;
  logic [BEAT_W-1:0] w_beats_m1;
  logic              w_last_beat;
  logic              w_pass_done;

  // Datapath steering: FIFO push/pop, output load, read issue and pass end.
  always_comb begin
    w_zin       = (r_mode == MODE_ZI);
    w_zout      = (r_mode == MODE_ZO);
    w_in_valid  = r_rd_d && r_keep_d;
    w_accept    = pixel_valid_out && pixel_ready_in;
    w_out_free  = !pixel_valid_out || (pixel_ready_in && (!w_zin || r_rep));
    w_load      = w_out_free && ((r_fifo_cnt != 2'd0) || w_in_valid);
    w_pop       = w_load && (r_fifo_cnt != 2'd0);
    w_push      = w_in_valid && !(w_load && (r_fifo_cnt == 2'd0));
    w_load_data = (r_fifo_cnt != 2'd0) ? r_fifo_mem[r_rd_ptr] : pixel_in;
    w_cnt_next  = 2'(r_fifo_cnt + {1'b0, w_push} - {1'b0, w_pop});
    w_issue     = (r_state == S_RUN) && (r_rd_cnt < RD_TOTAL) &&
                  (({1'b0, w_cnt_next} + {2'b00, line_rd_en_out}) < 3'd2);
    case (r_mode)
      MODE_ZI: w_beats_m1 = BEATS_ZI_M1;
      MODE_ZO: w_beats_m1 = BEATS_ZO_M1;
      default: w_beats_m1 = BEATS_1X_M1;
    endcase
    w_last_beat = (r_state == S_RUN) && w_accept && (r_out_cnt == w_beats_m1);
    w_pass_done = (r_beats_done || w_last_beat) && (r_rd_cnt == RD_TOTAL);
  end

  // Frame sequencer: state, counters and the registered control outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state          <= S_IDLE;
      r_mode           <= MODE_1X;
      r_row            <= '0;
      r_rd_cnt         <= '0;
      r_out_cnt        <= '0;
      r_pass           <= 1'b0;
      r_beats_done     <= 1'b0;
      r_rd_keep        <= 1'b0;
      line_rd_en_out   <= 1'b0;
      line_rewind_out  <= 1'b0;
      line_release_out <= 1'b0;
      busy_out         <= 1'b0;
      frame_done_out   <= 1'b0;
    end else begin
      line_rewind_out  <= 1'b0;
      line_release_out <= 1'b0;
      frame_done_out   <= 1'b0;
      line_rd_en_out   <= w_issue;
      r_rd_keep        <= w_issue && (!w_zout || !r_rd_cnt[0]);
      if (w_issue) begin
        r_rd_cnt <= r_rd_cnt + COL_ONE;
      end
      if ((r_state == S_RUN) && w_accept) begin
        r_out_cnt <= r_out_cnt + BEAT_ONE;
      end
      if (w_last_beat) begin
        r_beats_done <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          busy_out <= 1'b0;
          if (start_in) begin
            r_mode       <= (mode_in == 2'b11) ? MODE_1X : mode_in;
            r_row        <= '0;
            r_rd_cnt     <= '0;
            r_out_cnt    <= '0;
            r_pass       <= 1'b0;
            r_beats_done <= 1'b0;
            busy_out     <= 1'b1;
            r_state      <= S_WAIT_LINE;
          end
        end
        S_WAIT_LINE: begin
          if (line_ready_in) begin
            if (w_zout && r_row[0]) begin
              // Decimated row: drop the whole line without reading it.
              line_release_out <= 1'b1;
              r_row            <= r_row + ROW_ONE;
              if (r_row == ROW_LAST) begin
                r_state <= S_DONE;
              end
            end else begin
              r_rd_cnt     <= '0;
              r_out_cnt    <= '0;
              r_beats_done <= 1'b0;
              r_state      <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (w_pass_done) begin
            r_state <= S_LINE_END;
          end
        end
        S_LINE_END: begin
          if (w_zin && !r_pass) begin
            // Second pass of a replicated line reuses the same buffer line.
            line_rewind_out <= 1'b1;
            r_pass          <= 1'b1;
            r_rd_cnt        <= '0;
            r_out_cnt       <= '0;
            r_beats_done    <= 1'b0;
            r_state         <= S_RUN;
          end else begin
            line_release_out <= 1'b1;
            r_row            <= r_row + ROW_ONE;
            r_pass           <= 1'b0;
            r_state          <= (r_row == ROW_LAST) ? S_DONE : S_WAIT_LINE;
          end
        end
        S_DONE: begin
          frame_done_out <= 1'b1;
          busy_out       <= 1'b0;
          r_state        <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Skid FIFO and output register; in-flight read data is tracked here too.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_rd_d          <= 1'b0;
      r_keep_d        <= 1'b0;
      r_fifo_mem[0]   <= 8'd0;
      r_fifo_mem[1]   <= 8'd0;
      r_wr_ptr        <= 1'b0;
      r_rd_ptr        <= 1'b0;
      r_fifo_cnt      <= 2'd0;
      r_rep           <= 1'b0;
      pixel_out       <= 8'd0;
      pixel_valid_out <= 1'b0;
    end else begin
      r_rd_d     <= line_rd_en_out;
      r_keep_d   <= r_rd_keep;
      r_fifo_cnt <= w_cnt_next;
      if (w_push) begin
        r_fifo_mem[r_wr_ptr] <= pixel_in;
        r_wr_ptr             <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      if (w_load) begin
        pixel_out       <= w_load_data;
        pixel_valid_out <= 1'b1;
        r_rep           <= 1'b0;
      end else if (w_accept) begin
        if (w_zin && !r_rep) begin
          r_rep <= 1'b1;
        end else begin
          pixel_valid_out <= 1'b0;
          r_rep           <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_zoom_scheduler.sv
// Bench for zoom_scheduler with IMG_W=4, IMG_H=4: a line-buffer model serves
// pixel_in, a queue-based reference model gives the expected zoomed stream,
// and a table of frame scenarios (mode, ready density, injected disturbance)
// is run with randomized pixel_ready_in / line_ready_in.
module tb_zoom_scheduler;
  localparam int W = 4;
  localparam int H = 4;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic       start_in = 1'b0;
  logic [1:0] mode_in = 2'b00;
  logic       line_ready_in = 1'b0;
  logic       line_rd_en_out;
  logic       line_rewind_out;
  logic       line_release_out;
  logic [7:0] pixel_in = 8'd0;
  logic [7:0] pixel_out;
  logic       pixel_valid_out;
  logic       pixel_ready_in = 1'b0;
  logic       busy_out;
  logic       frame_done_out;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [1:0] mode;
    int         pct;
    int         inject;  // 0 none, 1 start/mode poke mid-frame, 2 reset at beat 3
    int         beats;
    int         rels;
    int         rews;
    int         reads;
  } vec_t;

  vec_t       tbl [8];
  logic [7:0] exp_q [$];
  int         buf_line = 0;
  int         buf_ptr = 0;
  logic       prev_rd = 1'b0;
  int         base = 0;

  always #5 clk_in = ~clk_in;

  zoom_scheduler #(.IMG_W(W), .IMG_H(H)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .start_in        (start_in),
    .mode_in         (mode_in),
    .line_ready_in   (line_ready_in),
    .line_rd_en_out  (line_rd_en_out),
    .line_rewind_out (line_rewind_out),
    .line_release_out(line_release_out),
    .pixel_in        (pixel_in),
    .pixel_out       (pixel_out),
    .pixel_valid_out (pixel_valid_out),
    .pixel_ready_in  (pixel_ready_in),
    .busy_out        (busy_out),
    .frame_done_out  (frame_done_out)
  );

  function automatic logic [7:0] pix(input int l, input int c);
    return 8'(base + 10 * (l + 1) + c);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference stream straight from the zoom rules.
  task automatic build_expected(input logic [1:0] m);
    exp_q.delete();
    for (int r = 0; r < H; r++) begin
      if (m == 2'b01) begin
        for (int p = 0; p < 2; p++)
          for (int c = 0; c < W; c++) begin
            exp_q.push_back(pix(r, c));
            exp_q.push_back(pix(r, c));
          end
      end else if (m == 2'b10) begin
        if (r % 2 == 0)
          for (int c = 0; c < W; c += 2) exp_q.push_back(pix(r, c));
      end else begin
        for (int c = 0; c < W; c++) exp_q.push_back(pix(r, c));
      end
    end
  endtask

  // One cycle at the falling edge: serve the buffer model, drive ready inputs.
  task automatic drive_cycle(input int pct);
    @(negedge clk_in);
    if (prev_rd) begin
      pixel_in = pix(buf_line, buf_ptr);
      buf_ptr++;
    end
    if (line_rewind_out === 1'b1) buf_ptr = 0;
    if (line_release_out === 1'b1) begin
      buf_line++;
      buf_ptr = 0;
    end
    prev_rd        = (line_rd_en_out === 1'b1);
    pixel_ready_in = ($urandom_range(99) < pct);
    line_ready_in  = ($urandom_range(99) < 80);
  endtask

  task automatic run_frame(input string tag, input vec_t v);
    int beats = 0, rels = 0, rews = 0, reads = 0, dones = 0;
    int excl = 0, unstable = 0, max_out = 0, outst = 0;
    int last_rel = -100, done_gap = -1, done_busy = 0, cur_line = 0;
    int tail = 0, busy_hi = 0;
    int line_reads [H];
    int line_rews [H];
    bit was_stall = 1'b0, seen_done = 1'b0, did_rst = 1'b0;
    logic [7:0] held = 8'd0;
    logic [1:0] em;
    for (int i = 0; i < H; i++) begin
      line_reads[i] = 0;
      line_rews[i]  = 0;
    end
    em = (v.mode == 2'b11) ? 2'b00 : v.mode;
    base = $urandom_range(100);
    buf_line = 0;
    buf_ptr = 0;
    build_expected(em);
    for (int k = 0; k < 3000; k++) begin
      drive_cycle(v.pct);
      if (did_rst) begin
        rst_in   = 1'b0;
        start_in = 1'b0;
        check({tag, " rst rd_en"}, int'(line_rd_en_out), 0);
        check({tag, " rst rewind"}, int'(line_rewind_out), 0);
        check({tag, " rst release"}, int'(line_release_out), 0);
        check({tag, " rst valid"}, int'(pixel_valid_out), 0);
        check({tag, " rst pixel"}, int'(pixel_out), 0);
        check({tag, " rst busy"}, int'(busy_out), 0);
        check({tag, " rst done"}, int'(frame_done_out), 0);
        return;
      end
      start_in = (k == 0) || (v.inject == 1 && k == 20);
      mode_in  = (k == 0) ? v.mode : 2'($urandom_range(3));
      if (line_rd_en_out) begin
        reads++;
        line_reads[cur_line]++;
      end
      if (line_rewind_out) begin
        rews++;
        line_rews[cur_line]++;
      end
      if ((line_rewind_out && line_release_out) ||
          (line_rd_en_out && (line_rewind_out || line_release_out))) excl++;
      if (k == 2 && busy_out) busy_hi = 1;
      if (was_stall && !(pixel_valid_out && pixel_out == held)) unstable++;
      outst = reads - beats;
      if (outst > max_out) max_out = outst;
      if (pixel_valid_out && pixel_ready_in) begin
        if (beats < exp_q.size())
          check($sformatf("%s pix[%0d]", tag, beats), int'(pixel_out), int'(exp_q[beats]));
        beats++;
      end
      was_stall = pixel_valid_out && !pixel_ready_in;
      held = pixel_out;
      if (line_release_out) begin
        rels++;
        last_rel = k;
        if (cur_line < H - 1) cur_line++;
      end
      if (frame_done_out) begin
        dones++;
        done_gap = k - last_rel;
        if (busy_out) done_busy++;
        seen_done = 1'b1;
      end
      if (v.inject == 2 && beats == 3 && !did_rst) begin
        rst_in   = 1'b1;
        did_rst  = 1'b1;
        prev_rd  = 1'b0;
        buf_line = 0;
        buf_ptr  = 0;
      end
      if (seen_done) tail++;
      if (tail > 4) break;
    end
    start_in = 1'b0;
    if (did_rst) begin
      rst_in = 1'b0;
      check({tag, " reset cycle reached"}, 0, 1);
      return;
    end
    check({tag, " frame_done seen"}, int'(seen_done), 1);
    check({tag, " beats"}, beats, v.beats);
    check({tag, " releases"}, rels, v.rels);
    check({tag, " rewinds"}, rews, v.rews);
    check({tag, " reads"}, reads, v.reads);
    check({tag, " done count"}, dones, 1);
    check({tag, " done after release"}, done_gap, 1);
    check({tag, " busy with done"}, done_busy, 0);
    check({tag, " busy after start"}, busy_hi, 1);
    check({tag, " control overlap"}, excl, 0);
    check({tag, " stall stability"}, unstable, 0);
    if (em == 2'b00) begin
      total++;
      if (max_out > 3) begin
        bad++;
        $display("FAIL %s outstanding: got %0d expected at most 3", tag, max_out);
      end
    end
    if (em == 2'b10)
      for (int l = 0; l < H; l++)
        check($sformatf("%s reads line %0d", tag, l), line_reads[l], (l % 2 == 1) ? 0 : W);
    if (em == 2'b01)
      for (int l = 0; l < H; l++)
        check($sformatf("%s rewinds line %0d", tag, l), line_rews[l], 1);
  endtask

  initial begin
    vec_t rv;
    tbl[0] = '{2'b00, 100, 0, 16, 4, 0, 16};
    tbl[1] = '{2'b01, 100, 0, 64, 4, 4, 32};
    tbl[2] = '{2'b10, 100, 0,  4, 4, 0,  8};
    tbl[3] = '{2'b00,  50, 0, 16, 4, 0, 16};
    tbl[4] = '{2'b11,  70, 0, 16, 4, 0, 16};
    tbl[5] = '{2'b01,  60, 0, 64, 4, 4, 32};
    tbl[6] = '{2'b10,  40, 0,  4, 4, 0,  8};
    tbl[7] = '{2'b00, 100, 1, 16, 4, 0, 16};

    rst_in = 1'b1;
    drive_cycle(100);
    drive_cycle(100);
    check("reset valid", int'(pixel_valid_out), 0);
    check("reset pixel", int'(pixel_out), 0);
    check("reset busy", int'(busy_out), 0);
    check("reset rd_en", int'(line_rd_en_out), 0);
    check("reset done", int'(frame_done_out), 0);
    rst_in = 1'b0;
    drive_cycle(100);

    for (int i = 0; i < 8; i++) begin
      run_frame($sformatf("vec%0d", i), tbl[i]);
      drive_cycle(100);
    end

    // Reset at beat 3 of line 0, then a clean frame from row 0, column 0.
    rv = '{2'b00, 100, 2, 16, 4, 0, 16};
    run_frame("rst_mid", rv);
    drive_cycle(100);
    rv.inject = 0;
    run_frame("after_rst", rv);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/zoom_scheduler.md
# zoom_scheduler

Sequences one frame of pixel reads from the line-buffer bank and produces the zoomed pixel stream for the zoom path. Three modes are supported: 1x pass-through, 2x zoom-in by pixel/line replication, and 2x zoom-out by pixel/line decimation. The block drives the buffer read enable and the rewind/release controls, absorbs the 1-cycle buffer read latency in a 2-entry skid FIFO, and presents a valid/ready stream to the downstream consumer.

## Interface
- IMG_W, 320, pixels per source line (even, ≥2)
- IMG_H, 240, source lines per frame (even, ≥2)
- Reset: one clock; reset is synchronous and active-high (clk_in, rst_in).
- clk_in  in  1  system clock
- rst_in  in  1  synchronous active-high reset
- start_in  in  1  frame start pulse; honoured only in IDLE
- mode_in  in  2  00 = 1x, 01 = zoom-in 2x, 10 = zoom-out 2x, 11 = treated as 00; latched on accepted start
- line_ready_in  in  1  a complete source line is available in the buffer
- line_rd_en_out  out  1  read next pixel of the current line; data arrives on pixel_in the next cycle
- line_rewind_out  out  1  1-cycle pulse; buffer read pointer returns to start of the current line
- line_release_out  out  1  1-cycle pulse; current line is consumed and may be overwritten
- pixel_in  in  8  buffer read data, valid the cycle after line_rd_en_out
- pixel_out  out  8  zoomed pixel
- pixel_valid_out  out  1  pixel_out is valid
- pixel_ready_in  in  1  downstream accepts the pixel when valid && ready
- busy_out  out  1  high in every state except IDLE
- frame_done_out  out  1  1-cycle pulse at end of frame

## Operation
- States: IDLE, WAIT_LINE, RUN, LINE_END, DONE.
- IDLE: when start_in is high, latch the mode, clear row, column and pass counters, and go to WAIT_LINE.
- WAIT_LINE: line_ready_in is sampled only in this state.
  - In zoom-out mode, an odd row with line_ready_in high pulses line_release_out with no reads, increments row, and stays in WAIT_LINE. If that row was the last row, go to DONE instead.
  - Otherwise, line_ready_in high moves to RUN.
- RUN: issue exactly IMG_W reads per pass.
  - A read is issued only when FIFO occupancy plus in-flight reads is less than 2.
  - In zoom-out mode, data for odd columns is discarded at the FIFO input.
  - When the last output beat of the pass is accepted, go to LINE_END.
- LINE_END:
  - Zoom-in, first pass: pulse line_rewind_out, set pass to 1, and return to RUN without waiting for line_ready_in.
  - Otherwise: pulse line_release_out and increment row. If the last source row is done, go to DONE; else go to WAIT_LINE.
- DONE: pulse frame_done_out and go to IDLE.
- Output beats:
  - 1x: each FIFO head is emitted once. Totals: IMG_W per line, IMG_W×IMG_H per frame.
  - Zoom-in: each FIFO head is held for 2 accepted beats, then popped. Each line is read twice. Total 4×IMG_W×IMG_H per frame.
  - Zoom-out: only even columns of even rows are emitted. Total (IMG_W/2)×(IMG_H/2) per frame.
- Counters are sized $clog2 of their maximum count. Column, row and repeat counters never wrap within a frame; all are cleared in IDLE.
- start_in outside IDLE is ignored. mode_in changes mid-frame are ignored.

## Timing
- All outputs are registered. Reset values: pixel_out = 0, and every 1-bit output = 0.
- pixel_valid_out and pixel_out have no combinational path from pixel_ready_in.
- Read latency: line_rd_en_out at cycle t → pixel_in sampled at t+1 → pixel_valid_out at t+2 at the earliest.
- Throughput: with pixel_ready_in held high, 1x mode sustains 1 beat per cycle after the first beat of a pass.
- pixel_ready_in low: pixel_out and pixel_valid_out hold stable, and reads stall once occupancy plus in-flight reaches 2. No data is lost or duplicated.
- line_rewind_out and line_release_out never assert in the same cycle, and never together with line_rd_en_out.
- frame_done_out fires 1 cycle after the final line_release_out. busy_out falls in the same cycle frame_done_out is asserted.
- Reset mid-frame: next cycle is IDLE, FIFO is empty, in-flight read data is dropped, and no release/rewind/done pulse is emitted.

## Test plan
- IMG_W=4, IMG_H=2, mode 00, ready held 1, line0 = 10,11,12,13 and line1 = 20..23:
  - Stream is 10,11,12,13,20,21,22,23.
  - 2 line_release_out pulses.
  - frame_done_out occurs once, 1 cycle after the last release.
- IMG_W=4, IMG_H=2, mode 01:
  - 32 beats: 10,10,11,11,12,12,13,13, repeated once, then the same pattern for line 1.
  - One line_rewind_out per line, before that line's release.
- IMG_W=4, IMG_H=4, mode 10:
  - Stream is line0 col0, col2, then line2 col0, col2 (4 beats).
  - Odd lines are released with zero line_rd_en_out pulses.
  - 4 releases total.
- Mode 00, pixel_ready_in toggling in a pseudo-random pattern:
  - Stream content and order match the ready-high case.
  - pixel_out is stable while valid && !ready.
  - Occupancy plus in-flight reads never exceeds 2.
- rst_in asserted at beat 3 of line 0, then a new start_in:
  - IDLE and all outputs are 0 the cycle after reset.
  - The new frame starts clean from column 0, row 0.
- start_in pulsed and mode_in changed in the middle of a mode-00 frame:
  - No effect: beat count stays IMG_W×IMG_H.
  - Exactly one frame_done_out.
